// File: rtl/hash_clk_governor.sv
// Fractional clock-enable generator for the hasher cores: NUM_CH staggered
// enables from one PLL clock, with slew-limited ramp, lock supervision and error backoff.
module hash_clk_governor #(
  parameter int NUM_CH      = 4,
  parameter int RATE_W      = 8,
  parameter int MIN_RATE    = 16,
  parameter int RAMP_DIV    = 1024,
  parameter int LOCK_SETTLE = 256,
  parameter int HOLD_CYCLES = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              req_valid,
  input  logic [RATE_W:0]   req_rate,
  output logic              req_ready,
  input  logic [NUM_CH-1:0] err,
  output logic [NUM_CH-1:0] ce,
  output logic [RATE_W:0]   cur_rate,
  output logic              at_target,
  output logic [1:0]        state,
  output logic [15:0]       err_count
);

  localparam int SETTLE_W = $clog2(LOCK_SETTLE + 1);
  localparam int RAMP_W   = $clog2(RAMP_DIV);
  localparam int HOLD_W   = $clog2(HOLD_CYCLES + 1);
  localparam int RW1      = RATE_W + 1;

  localparam logic [RATE_W:0]     FULL_RATE   = {1'b1, {RATE_W{1'b0}}};
  localparam logic [RATE_W:0]     MIN_R       = RW1'(MIN_RATE);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(LOCK_SETTLE - 1);
  localparam logic [RAMP_W-1:0]   RAMP_LAST   = RAMP_W'(RAMP_DIV - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    LOCKWAIT = 2'd0,
    RAMP     = 2'd1,
    HOLD     = 2'd2,
    STEADY   = 2'd3
  } state_t;

  function automatic logic [RATE_W:0] clamp_rate(input logic [RATE_W:0] r);
    return (r > FULL_RATE) ? FULL_RATE : r;
  endfunction

  function automatic logic [RATE_W:0] backoff_rate(input logic [RATE_W:0] r);
    logic [RATE_W:0] h;
    h = r - (r >> 1);
    return (h < MIN_R) ? MIN_R : h;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [NUM_CH-1:0] e);
    logic [16:0] s;
    s = {1'b0, a};
    for (int i = 0; i < NUM_CH; i++) s = s + {16'd0, e[i]};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Phase offsets spread the enables evenly around the accumulator circle.
  function automatic logic [RATE_W-1:0] ch_offset(input int i);
    return RATE_W'((64'(i) << RATE_W) / 64'(NUM_CH));
  endfunction

  logic                lk_meta, lk_s;
  state_t              st_q, st_n;
  logic [SETTLE_W-1:0] settle_q, settle_n;
  logic [RAMP_W-1:0]   ramp_q, ramp_n;
  logic [HOLD_W-1:0]   hold_q, hold_n;
  logic [RATE_W:0]     rate_q, rate_n;
  logic [RATE_W:0]     tgt_q, tgt_n;
  logic [RATE_W-1:0]   acc_q [NUM_CH];
  logic [NUM_CH-1:0]   ce_q;
  logic [15:0]         err_cnt_q;
  logic                at_q;
  logic                lock_lost, any_err, run;

  assign lock_lost = (st_q != LOCKWAIT) && !lk_s;
  assign any_err   = |err;
  assign run       = (st_q != LOCKWAIT) && lk_s;

  assign req_ready = (st_q != HOLD);
  assign ce        = ce_q;
  assign cur_rate  = rate_q;
  assign at_target = at_q;
  assign state     = st_q;
  assign err_count = err_cnt_q;

  always_comb begin
    st_n     = st_q;
    rate_n   = rate_q;
    tgt_n    = tgt_q;
    settle_n = settle_q;
    ramp_n   = ramp_q;
    hold_n   = hold_q;
    if (req_valid && req_ready) tgt_n = clamp_rate(req_rate);
    if (lock_lost) begin
      st_n     = LOCKWAIT;
      rate_n   = MIN_R;
      settle_n = '0;
      ramp_n   = '0;
      hold_n   = '0;
    end else begin
      case (st_q)
        LOCKWAIT: begin
          if (!lk_s) begin
            settle_n = '0;
          end else if (settle_q == SETTLE_LAST) begin
            st_n     = RAMP;
            settle_n = '0;
            ramp_n   = '0;
          end else begin
            settle_n = settle_q + 1'b1;
          end
        end
        RAMP: begin
          // A target lowered mid-ramp is applied at once, like in STEADY.
          if (rate_q >= tgt_q) begin
            rate_n = tgt_q;
            st_n   = STEADY;
          end else if (ramp_q == RAMP_LAST) begin
            ramp_n = '0;
            rate_n = rate_q + 1'b1;
          end else begin
            ramp_n = ramp_q + 1'b1;
          end
        end
        STEADY: begin
          if (tgt_q > rate_q) begin
            st_n   = RAMP;
            ramp_n = '0;
          end else begin
            rate_n = tgt_q;
          end
        end
        HOLD: begin
          if (any_err) hold_n = HOLD_LAST;
          else if (hold_q == '0) st_n = STEADY;
          else hold_n = hold_q - 1'b1;
        end
      endcase
      // Backoff wins over any request accepted in the same cycle.
      if (any_err && (st_q == RAMP || st_q == STEADY)) begin
        rate_n = backoff_rate(rate_q);
        tgt_n  = backoff_rate(rate_q);
        st_n   = HOLD;
        hold_n = HOLD_LAST;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta   <= 1'b0;
      lk_s      <= 1'b0;
      st_q      <= LOCKWAIT;
      settle_q  <= '0;
      ramp_q    <= '0;
      hold_q    <= '0;
      rate_q    <= MIN_R;
      tgt_q     <= MIN_R;
      err_cnt_q <= '0;
      at_q      <= 1'b0;
    end else begin
      lk_meta   <= pll_locked;
      lk_s      <= lk_meta;
      st_q      <= st_n;
      settle_q  <= settle_n;
      ramp_q    <= ramp_n;
      hold_q    <= hold_n;
      rate_q    <= rate_n;
      tgt_q     <= tgt_n;
      err_cnt_q <= sat_add(err_cnt_q, err);
      at_q      <= (rate_n == tgt_n) && (st_n == STEADY);
    end
  end

  // Enable stage: carry out of each phase accumulator is the registered enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_q <= '0;
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= ch_offset(i);
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (run) begin
          {ce_q[i], acc_q[i]} <= {1'b0, acc_q[i]} + rate_q;
        end else begin
          ce_q[i]  <= 1'b0;
          acc_q[i] <= ch_offset(i);
        end
      end
    end
  end

endmodule
